// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory-port arbiter.
//   - arb_state_e : transaction FSM states (IDLE, ISSUE, WAIT, DONE)
//   - REQ_CACHE / REQ_FETCH : requester index constants into Req/Gnt/Done
//   - DEF_AW / DEF_DW : default address and data widths
package mem_arb_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 32;

  localparam int REQ_CACHE = 0;
  localparam int REQ_FETCH = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bus between the two requesters / memory and the arbiter.
//   Requester side : Req[1:0], Lectura_Escritura[1:0] (1=read, 0=write),
//                    Addr0/Addr1 [AW], WData0/WData1 [DW]
//   Memory side    : PNDNG (1 = transaction finished)
//   Arbiter drives : Gnt[1:0], Done[1:0], Mem_Eneable, Mem_R_W,
//                    Mem_Addr [AW], Mem_WData [DW], Timeout
// Modports: master = environment (requesters + memory), slave = arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic [1:0]    Req;
  logic [1:0]    Lectura_Escritura;
  logic [AW-1:0] Addr0;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] WData0;
  logic [DW-1:0] WData1;
  logic          PNDNG;

  logic [1:0]    Gnt;
  logic [1:0]    Done;
  logic          Mem_Eneable;
  logic          Mem_R_W;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_WData;
  logic          Timeout;

  modport master (
    output Req, Lectura_Escritura, Addr0, Addr1, WData0, WData1, PNDNG,
    input  Gnt, Done, Mem_Eneable, Mem_R_W, Mem_Addr, Mem_WData, Timeout
  );

  modport slave (
    input  Req, Lectura_Escritura, Addr0, Addr1, WData0, WData1, PNDNG,
    output Gnt, Done, Mem_Eneable, Mem_R_W, Mem_Addr, Mem_WData, Timeout
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational two-way round-robin winner selector.
//   req    [1:0] : per-requester request
//   ptr          : index of the requester served last (it loses a tie)
//   winner [1:0] : one-hot winner, 00 when nobody requests
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] winner
);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    winner = 2'b00;
    unique case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = (ptr == 1'(REQ_FETCH)) ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule : mem_arb_rr

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the cache controller
// (requester 0) and the fetch unit (requester 1).
//   CLK, RST : clock and synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (requests in, grant/memory strobes out)
// Each transaction runs IDLE -> ISSUE (1-cycle address setup) -> WAIT (strobe
// high until PNDNG) -> DONE (1-cycle Done pulse) -> IDLE. Request fields are
// latched on leaving IDLE, so later Req changes do not disturb a transaction.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles, flagging Timeout during the resulting DONE cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               CLK,
  input logic               RST,
  mem_port_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e    state_q, state_d;
  logic [1:0]    winner;
  logic [1:0]    served_q;   // one-hot requester owning the current transaction
  logic          ptr_q;      // index of the last requester to complete
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          timeout_hit;

  mem_arb_rr u_rr (
    .req    (bus.Req),
    .ptr    (ptr_q),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (winner != 2'b00) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.PNDNG || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (RST) begin
      state_q  <= IDLE;
      served_q <= 2'b00;
      ptr_q    <= 1'(REQ_FETCH);  // fetch "served last" -> cache has priority
      rw_q     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && winner != 2'b00) begin
        served_q <= winner;
        if (winner[REQ_FETCH]) begin
          rw_q    <= bus.Lectura_Escritura[REQ_FETCH];
          addr_q  <= bus.Addr1;
          wdata_q <= bus.WData1;
        end else begin
          rw_q    <= bus.Lectura_Escritura[REQ_CACHE];
          addr_q  <= bus.Addr0;
          wdata_q <= bus.WData0;
        end
      end
      if (state_q == DONE) ptr_q <= served_q[REQ_FETCH];
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wdog_q;     // WAIT cycles already elapsed in this transaction
  logic          timeout_q;

  // Fires in the last allowed WAIT cycle if memory still has not answered.
  assign timeout_hit = (state_q == WAIT) && !bus.PNDNG &&
                       (wdog_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= (state_q == WAIT) ? wdog_q + 1'b1 : '0;
      timeout_q <= timeout_hit;  // high exactly for the DONE cycle it caused
    end
  end

  assign bus.Timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.Timeout = 1'b0;
`endif

  // Grant/strobe/pulse outputs decode from state and the latched owner only.
  assign bus.Gnt         = (state_q == ISSUE || state_q == WAIT) ? served_q : 2'b00;
  assign bus.Done        = (state_q == DONE) ? served_q : 2'b00;
  assign bus.Mem_Eneable = (state_q == WAIT);
  assign bus.Mem_R_W     = rw_q;
  assign bus.Mem_Addr    = addr_q;
  assign bus.Mem_WData   = wdata_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// A transaction-level model predicts every output each cycle; a compare
// process checks it on the falling edge, and the directed scenarios add
// hand-computed literal expectations. Build with or without
// MEM_ARB_TIMEOUT_EN; the watchdog scenario adapts to the macro.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam int TO_LIMIT = 255;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (TO_LIMIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  // ---------------- transaction-level model ----------------
  // m_busy: a requester holds the grant; m_wait: memory strobe phase;
  // m_done: completion-pulse cycle; m_last: requester that completed last.
  bit            m_busy = 0, m_wait = 0, m_done = 0, m_to = 0;
  int            m_srv = 0, m_last = 1, m_wcnt = 0;
  logic          m_rw = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  always @(posedge CLK) begin
    if (RST) begin
      m_busy = 0; m_wait = 0; m_done = 0; m_to = 0;
      m_last = 1; m_wcnt = 0;
      m_rw = 1'b1; m_addr = '0; m_wdata = '0;
    end else if (m_done) begin
      m_done = 0; m_to = 0; m_last = m_srv;
    end else if (m_wait) begin
      m_wcnt++;
      if (bus.PNDNG || (TO_EN && m_wcnt == TO_LIMIT)) begin
        m_to = !bus.PNDNG;
        m_wait = 0; m_busy = 0; m_done = 1;
      end
    end else if (m_busy) begin
      m_wait = 1; m_wcnt = 0;
    end else if (bus.Req != 2'b00) begin
      if (bus.Req == 2'b11) m_srv = (m_last == 0) ? 1 : 0;
      else                  m_srv = bus.Req[1] ? 1 : 0;
      m_busy  = 1;
      m_rw    = bus.Lectura_Escritura[m_srv];
      m_addr  = (m_srv == 1) ? bus.Addr1 : bus.Addr0;
      m_wdata = (m_srv == 1) ? bus.WData1 : bus.WData0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cmp_gnt",   bus.Gnt,  m_busy ? onehot(m_srv) : 2'b00);
      check("cmp_done",  bus.Done, m_done ? onehot(m_srv) : 2'b00);
      check("cmp_en",    bus.Mem_Eneable, m_wait);
      check("cmp_rw",    bus.Mem_R_W, m_rw);
      check("cmp_addr",  bus.Mem_Addr, m_addr);
      check("cmp_wdata", bus.Mem_WData, m_wdata);
      check("cmp_tout",  bus.Timeout, m_to);
      check("cmp_excl",  (bus.Gnt != 2'b00) && (bus.Done != 2'b00), 1'b0);
      check("cmp_onehot", $onehot0(bus.Gnt) && $onehot0(bus.Done), 1'b1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},   bus.Gnt, 2'b00);
    check({tag, "_done"},  bus.Done, 2'b00);
    check({tag, "_en"},    bus.Mem_Eneable, 1'b0);
    check({tag, "_rw"},    bus.Mem_R_W, 1'b1);
    check({tag, "_addr"},  bus.Mem_Addr, 16'h0000);
    check({tag, "_wdata"}, bus.Mem_WData, 32'h0);
    check({tag, "_tout"},  bus.Timeout, 1'b0);
  endtask

  // Expected Gnt/Done per cycle for two requesters held with PNDNG=1.
  logic [1:0] s2_gnt  [12] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10,
                               2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  logic [1:0] s2_done [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00,
                               2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};

  initial begin
    int  n_en;
    bit  seen;

    bus.Req = 2'b00; bus.Lectura_Escritura = 2'b00;
    bus.Addr0 = '0; bus.Addr1 = '0; bus.WData0 = '0; bus.WData1 = '0;
    bus.PNDNG = 1'b0;

    // Reset
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    chk_en = 1'b1;
    check_reset_values("rst0");

    // Single cache read, Req dropped after one cycle, PNDNG on first WAIT cycle
    bus.Req = 2'b01; bus.Lectura_Escritura = 2'b01; bus.Addr0 = 16'h1234;
    tick();
    check("s1_gnt_issue", bus.Gnt, 2'b01);
    check("s1_en_issue",  bus.Mem_Eneable, 1'b0);
    check("s1_addr",      bus.Mem_Addr, 16'h1234);
    check("s1_rw",        bus.Mem_R_W, 1'b1);
    bus.Req = 2'b00; bus.PNDNG = 1'b1;
    tick();
    check("s1_gnt_wait", bus.Gnt, 2'b01);
    check("s1_en_wait",  bus.Mem_Eneable, 1'b1);
    tick();
    check("s1_done",     bus.Done, 2'b01);
    check("s1_gnt_done", bus.Gnt, 2'b00);
    bus.PNDNG = 1'b0;
    tick();
    check("s1_idle_done", bus.Done, 2'b00);

    // Reset again so both requesters start from cache priority
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset_values("rst1");

    // Both requesters held, memory answers immediately: grants alternate
    bus.Req = 2'b11; bus.Lectura_Escritura = 2'b10; bus.PNDNG = 1'b1;
    bus.Addr0 = 16'h0100; bus.Addr1 = 16'h0200;
    for (int t = 0; t < 12; t++) begin
      tick();
      check($sformatf("s2_gnt_%0d", t), bus.Gnt, s2_gnt[t]);
      check($sformatf("s2_done_%0d", t), bus.Done, s2_done[t]);
      if (t == 4) check("s2_fetch_addr", bus.Mem_Addr, 16'h0200);
      if (t == 10) bus.Req = 2'b00;
    end
    bus.PNDNG = 1'b0;

    // Fetch write with 5 stalled WAIT cycles
    bus.Req = 2'b10; bus.Lectura_Escritura = 2'b00;
    bus.Addr1 = 16'h0BEE; bus.WData1 = 32'hDEADBEEF;
    tick();
    check("s3_gnt_issue", bus.Gnt, 2'b10);
    bus.Req = 2'b00;
    n_en = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus.Mem_Eneable) n_en++;
      check($sformatf("s3_wdata_%0d", i), bus.Mem_WData, 32'hDEADBEEF);
      if (i == 6) bus.PNDNG = 1'b1;
    end
    check("s3_en_cycles", n_en, 6);
    tick();
    check("s3_done", bus.Done, 2'b10);
    check("s3_en_done", bus.Mem_Eneable, 1'b0);
    bus.PNDNG = 1'b0;
    tick();

    // Same single requester again right after being served: still wins
    bus.Req = 2'b10; bus.PNDNG = 1'b1;
    tick();
    check("s3b_gnt", bus.Gnt, 2'b10);
    bus.Req = 2'b00;
    tick(); tick();
    check("s3b_done", bus.Done, 2'b10);
    bus.PNDNG = 1'b0;
    tick();

    // Reset during WAIT aborts without a Done pulse
    bus.Req = 2'b01; bus.Lectura_Escritura = 2'b00;
    bus.Addr0 = 16'h00AA; bus.WData0 = 32'h55;
    tick();
    bus.Req = 2'b00;
    tick();
    check("s4_en_wait", bus.Mem_Eneable, 1'b1);
    check("s4_wdata",   bus.Mem_WData, 32'h55);
    RST = 1'b1; bus.PNDNG = 1'b1;
    tick();
    check_reset_values("s4_rst");
    RST = 1'b0; bus.PNDNG = 1'b0;
    tick();
    check("s4_no_done", bus.Done, 2'b00);
    check("s4_idle_gnt", bus.Gnt, 2'b00);

    // Memory never answers
    bus.Req = 2'b01;
    tick();
    bus.Req = 2'b00;
    n_en = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (bus.Done != 2'b00) seen = 1'b1;
      else if (bus.Mem_Eneable) n_en++;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("s5_done_seen", seen, 1'b1);
    check("s5_wait_len",  n_en, TO_LIMIT);
    check("s5_done",      bus.Done, 2'b01);
    check("s5_tout",      bus.Timeout, 1'b1);
    tick();
    check("s5_tout_clr",  bus.Timeout, 1'b0);
`else
    check("s5_no_done",   seen, 1'b0);
    check("s5_wait_len",  n_en, 400);
    check("s5_tout",      bus.Timeout, 1'b0);
    check("s5_en_stuck",  bus.Mem_Eneable, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
`endif
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the parameter AW, default 16: address width.
REQ-002 The block SHALL have the parameter DW, default 32: data width.
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 255: WAIT-state cycle limit, used only with the watchdog compiled in.
REQ-004 The block SHALL have port CLK  in  1: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST  in  1: reset, synchronous and active-high.
REQ-006 The block SHALL have port Req  in  2: per-requester request; bit 0 is the cache controller, bit 1 is the fetch unit.
REQ-007 The block SHALL have port Lectura_Escritura  in  2: per-requester direction; 1 is read, 0 is write.
REQ-008 The block SHALL have ports Addr0 and Addr1  in  AW: per-requester address.
REQ-009 The block SHALL have ports WData0 and WData1  in  DW: per-requester write data.
REQ-010 The block SHALL have port PNDNG  in  1: memory completion indicator; 1 means the transaction is finished.
REQ-011 The block SHALL have port Gnt  out  2: one-hot grant, held for the whole transaction.
REQ-012 The block SHALL have port Done  out  2: one-cycle completion pulse to the granted requester.
REQ-013 The block SHALL have port Mem_Eneable  out  1: memory request strobe.
REQ-014 The block SHALL have port Mem_R_W  out  1: latched direction.
REQ-015 The block SHALL have port Mem_Addr  out  AW: latched address.
REQ-016 The block SHALL have port Mem_WData  out  DW: latched write data.
REQ-017 The block SHALL have port Timeout  out  1: watchdog abort flag.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered or decoded from state only.
REQ-019 In IDLE with Req!=0, the FSM SHALL select a winner, latch its Lectura_Escritura, Addr and WData into Mem_R_W, Mem_Addr and Mem_WData, set Gnt to the winner, and go to ISSUE.
REQ-020 In IDLE with Req==0, the FSM SHALL stay in IDLE with Gnt=00.
REQ-021 Arbitration SHALL be round-robin: the last-served requester has lowest priority; a single requester SHALL always win.
REQ-022 ISSUE SHALL last exactly 1 cycle as address setup: Gnt held, Mem_Eneable=0, PNDNG ignored; next state is WAIT.
REQ-023 In WAIT, Mem_Eneable SHALL be 1 and Mem_* SHALL be stable; when PNDNG=1 is sampled, the FSM SHALL go to DONE.
REQ-024 In DONE, for 1 cycle: Done[winner]=1, Gnt=00, Mem_Eneable=0, round-robin pointer updated to the winner; next state is IDLE.
REQ-025 Minimum latency SHALL be: Req sampled at edge k, Gnt high after k, Mem_Eneable high after k+1, Done high after k+2 if PNDNG=1 at k+2.
REQ-026 Once latched, a transaction SHALL complete even if the requester drops Req; Req changes in ISSUE, WAIT and DONE SHALL be ignored.
REQ-027 A requester holding Req through DONE SHALL be rearbitrated in the following IDLE cycle; no back-to-back issue without passing through IDLE.
REQ-028 Gnt and Done SHALL never both be nonzero in the same cycle, and each SHALL be at most one-hot.

Reset
REQ-029 With RST=1 at an edge, the block SHALL enter IDLE, with Gnt=00, Done=00, Mem_Eneable=0, Mem_R_W=1, Mem_Addr=0, Mem_WData=0, Timeout=0, watchdog counter=0, and pointer giving requester 0 priority.
REQ-030 Reset mid-transaction SHALL abort the transaction with no Done pulse; RST SHALL override all other inputs.

Configuration
REQ-031 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYCLES without PNDNG, the FSM SHALL go to DONE, with Done pulsing normally and Timeout=1 for that DONE cycle.
REQ-032 Without MEM_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter SHALL be synthesized, and Timeout SHALL be tied to 0.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum, the requester index constants (REQ_CACHE=0, REQ_FETCH=1) and the default AW/DW.
REQ-034 Sub-module mem_arb_rr SHALL be the combinational round-robin winner selector (inputs Req and pointer; output one-hot winner).

Verification
REQ-035 Req=01, Addr0=0x1234, Lectura_Escritura=01, PNDNG=1 on first WAIT cycle -> Gnt=01 for 2 cycles, Mem_Addr=0x1234, Mem_R_W=1, Done=01 pulse 3 cycles after request.
REQ-036 Req=11 held after reset, PNDNG=1 immediately each time -> grants alternate 01, 10, 01; Done pulses alternate correspondingly.
REQ-037 Req=10 write, WData1=0xDEADBEEF, PNDNG held 0 for 5 WAIT cycles -> Mem_Eneable high 6 cycles, Mem_WData stable at 0xDEADBEEF, then Done=10.
REQ-038 Req=01 dropped after 1 cycle -> transaction still completes with Done=01; RST asserted in WAIT -> next cycle IDLE, all outputs at reset values, no Done.
REQ-039 With MEM_ARB_TIMEOUT_EN, PNDNG stuck 0 -> after 255 WAIT cycles, DONE with Timeout=1 and Done pulse; without the macro -> the FSM remains in WAIT and Timeout stays 0.
